// File: rtl/nfi_pkg.sv
// Shared types and rule constants for the next-field-iteration engine.
package nfi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        SWAP
    } nfi_state_t;

    // B3/S23: a dead cell with three neighbours is born, a live cell with two survives.
    localparam int RULE_BIRTH   = 3;
    localparam int RULE_SURVIVE = 2;

endpackage

// File: rtl/gol_row_next.sv
// Combinational next-generation row for Game of Life with toroidal column wrap.
module gol_row_next
    import nfi_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] row_above_i,
    input  logic [WIDTH-1:0] row_cur_i,
    input  logic [WIDTH-1:0] row_below_i,
    output logic [WIDTH-1:0] row_next_o
);

    for (genvar c = 0; c < WIDTH; c++) begin : g_col
        localparam int L = (c == 0) ? WIDTH - 1 : c - 1;
        localparam int R = (c == WIDTH - 1) ? 0 : c + 1;

        logic [3:0] nbrs;

        assign nbrs = 4'(row_above_i[L]) + 4'(row_above_i[c]) + 4'(row_above_i[R])
                    + 4'(row_cur_i[L])                         + 4'(row_cur_i[R])
                    + 4'(row_below_i[L]) + 4'(row_below_i[c]) + 4'(row_below_i[R]);

        assign row_next_o[c] = (nbrs == 4'(RULE_BIRTH))
                             | (row_cur_i[c] & (nbrs == 4'(RULE_SURVIVE)));
    end

endmodule

// File: rtl/nfi_engine.sv
// Double-buffered Game of Life field: computes one row per clock into the shadow
// buffer on each accepted go, then swaps buffers and reports completion.
module nfi_engine
    import nfi_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int HEIGHT   = 24,
    parameter  int GEN_BITS = 16,
    localparam int ROW_BITS = $clog2(HEIGHT)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_go,
    output logic                o_NFI_allowed,
    output logic                o_done,
    output logic [GEN_BITS-1:0] o_generation,
    input  logic                i_wr_en,
    input  logic [ROW_BITS-1:0] i_wr_row,
    input  logic [WIDTH-1:0]    i_wr_data,
    input  logic [ROW_BITS-1:0] i_rd_row,
    output logic [WIDTH-1:0]    o_rd_data
);

    localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(HEIGHT - 1);

    nfi_state_t          state_q;
    logic [ROW_BITS-1:0] row_q;
    logic                act_sel_q;
    logic                allowed_q;
    logic                done_q;
    logic [GEN_BITS-1:0] gen_q;
    logic [WIDTH-1:0]    rd_data_q;
    logic [WIDTH-1:0]    field_q [2][HEIGHT];

    logic [ROW_BITS-1:0] row_up_d;
    logic [ROW_BITS-1:0] row_dn_d;
    logic [WIDTH-1:0]    row_next_d;
    logic                wr_ok_d;
    logic                rd_ok_d;

    // Neighbour row indices wrap vertically; range checks for the write and read ports.
    always_comb begin
        row_up_d = (row_q == '0) ? LAST_ROW : row_q - 1'b1;
        row_dn_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
        wr_ok_d  = i_wr_en && (32'(i_wr_row) < 32'(HEIGHT));
        rd_ok_d  = (32'(i_rd_row) < 32'(HEIGHT));
    end

    gol_row_next #(
        .WIDTH (WIDTH)
    ) u_row_next (
        .row_above_i (field_q[act_sel_q][row_up_d]),
        .row_cur_i   (field_q[act_sel_q][row_q]),
        .row_below_i (field_q[act_sel_q][row_dn_d]),
        .row_next_o  (row_next_d)
    );

    // FSM, field storage, counters and registered outputs.
    // The buffer select flips on the same edge that writes the final shadow row,
    // so done and the new field become visible together while the FSM sits in SWAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            row_q     <= '0;
            act_sel_q <= 1'b0;
            allowed_q <= 1'b1;
            done_q    <= 1'b0;
            gen_q     <= '0;
            rd_data_q <= '0;
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned r = 0; r < HEIGHT; r++) begin
                    field_q[b][r] <= '0;
                end
            end
        end else begin
            done_q    <= 1'b0;
            rd_data_q <= rd_ok_d ? field_q[act_sel_q][i_rd_row] : '0;
            unique case (state_q)
                IDLE: begin
                    if (wr_ok_d) begin
                        field_q[act_sel_q][i_wr_row] <= i_wr_data;
                    end
                    if (i_go) begin
                        state_q   <= COMPUTE;
                        row_q     <= '0;
                        allowed_q <= 1'b0;
                    end
                end
                COMPUTE: begin
                    field_q[~act_sel_q][row_q] <= row_next_d;
                    if (row_q == LAST_ROW) begin
                        state_q   <= SWAP;
                        row_q     <= '0;
                        act_sel_q <= ~act_sel_q;
                        gen_q     <= gen_q + 1'b1;
                        done_q    <= 1'b1;
                    end else begin
                        row_q <= row_q + 1'b1;
                    end
                end
                SWAP: begin
                    state_q   <= IDLE;
                    allowed_q <= 1'b1;
                end
                default: begin
                    state_q   <= IDLE;
                    allowed_q <= 1'b1;
                end
            endcase
        end
    end

    assign o_NFI_allowed = allowed_q;
    assign o_done        = done_q;
    assign o_generation  = gen_q;
    assign o_rd_data     = rd_data_q;

endmodule
